// File: rtl/mod_arith_pkg.sv
// Shared constants for the sequential modular-arithmetic blocks:
// operand width, FSM state encoding and fixed latencies.
package mod_arith_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        REDUCE = 3'd2,
        MUL    = 3'd3,
        FIN    = 3'd4
    } mmul_state_e;

    // Edges from the start-sampling edge to done, for m != 0 and m == 0.
    localparam int MMUL_LAT    = 66;
    localparam int MMUL_LAT_M0 = 2;

endpackage

// File: rtl/cond_sub.sv
// Conditional subtract: brings a value below 2m back into [0, m).
module cond_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] y_o
);

    assign y_o = (x_i >= m_i) ? x_i - m_i : x_i;

endmodule

// File: rtl/mod_mul_seq.sv
// Bit-serial modular multiplier: first reduces a mod m (MSB-first), then
// runs a double-and-add over b's bits, keeping every partial value below m.
module mod_mul_seq
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = mod_arith_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int EW = WIDTH + 1;
    localparam int IW = $clog2(WIDTH);

    mmul_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [EW-1:0]    r_q, r_d, acc_q, acc_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [EW-1:0] m_ext;
    logic [EW-1:0] red_sum, red_out;
    logic [EW-1:0] mul_dbl, mul_s1, mul_add, mul_s2;

    // Partial values stay below m, so one extra bit absorbs every 2x or +r step.
    assign m_ext   = {1'b0, m_q};
    assign red_sum = (r_q << 1) | EW'(a_q[i_q]);
    assign mul_dbl = acc_q << 1;
    assign mul_add = mul_s1 + (b_q[i_q] ? r_q : '0);

    cond_sub #(.W(EW)) u_sub_red  (.x_i(red_sum), .m_i(m_ext), .y_o(red_out));
    cond_sub #(.W(EW)) u_sub_dbl  (.x_i(mul_dbl), .m_i(m_ext), .y_o(mul_s1));
    cond_sub #(.W(EW)) u_sub_add  (.x_i(mul_add), .m_i(m_ext), .y_o(mul_s2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = (m == '0) ? FIN : REDUCE;
            REDUCE:  state_d = (i_q == '0) ? MUL : REDUCE;
            MUL:     state_d = (i_q == '0) ? FIN : MUL;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        r_d      = r_q;
        acc_d    = acc_q;
        i_d      = i_q;
        result_d = result_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: done_d = ~start;
            LOAD: begin
                a_d   = a;
                b_d   = b;
                m_d   = m;
                r_d   = '0;
                acc_d = '0;
                i_d   = IW'(WIDTH - 1);
            end
            REDUCE: begin
                r_d = red_out;
                i_d = (i_q == '0) ? IW'(WIDTH - 1) : i_q - IW'(1);
            end
            MUL: begin
                acc_d = mul_s2;
                i_d   = i_q - IW'(1);
            end
            FIN: begin
                result_d = acc_q[WIDTH-1:0];
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: doc/mod_mul_seq.md
MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

Interface
REQ-001 Ports SHALL be (clock and reset first): clk input 1 clock; reset input 1 reset, synchronous, active-high; start input 1 one-cycle request pulse; a input 32 multiplicand; b input 32 multiplier; m input 32 modulus; result output 32 registered (a*b) mod m; done output 1 registered idle/complete flag.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and result width; all latency figures below apply to WIDTH=32.

Function
REQ-003 The block SHALL compute result = (a*b) mod m on unsigned WIDTH-bit operands, without a WIDTH x WIDTH multiplier.
REQ-004 The FSM SHALL have these states: IDLE, LOAD, REDUCE, MUL, FIN.
REQ-005 In IDLE with start=1, the next state SHALL be LOAD and done SHALL be 0; with start=0, the next state SHALL be IDLE and done SHALL be 1.
REQ-006 After start is sampled, done SHALL be 0 at the following edge, so that a caller checking done two cycles after raising start sees it low.
REQ-007 In LOAD, the block SHALL capture a, b and m into internal registers, clear r and acc, and set bit index i=WIDTH-1; if m==0 the next state SHALL be FIN with acc=0, otherwise REDUCE.
REQ-008 Each REDUCE cycle SHALL perform r = 2r + a_reg[i], then subtract m once if r >= m, then decrement i; after i==0 the block SHALL set i=WIDTH-1 and go to MUL, leaving r = a mod m.
REQ-009 Each MUL cycle SHALL perform acc = 2acc, subtract m once if acc >= m, add r if b_reg[i]==1, subtract m once more if acc >= m, then decrement i; after i==0 the next state SHALL be FIN.
REQ-010 Intermediate arithmetic SHALL use WIDTH+1 bits; every sum is < 2m, so one conditional subtract per step is sufficient and no overflow can occur.
REQ-011 FIN SHALL load result with acc and done with 1, then return to IDLE.
REQ-012 For m!=0, done SHALL rise at edge E0+66, where E0 is the edge that sampled start; the latency SHALL be fixed and independent of the data.
REQ-013 For m==0, the block SHALL give result=0 with done=1 at edge E0+2.
REQ-014 The block SHALL ignore start outside IDLE; captured operands SHALL remain unchanged until FIN.
REQ-015 result SHALL hold its value until the next FIN; changes on a, b or m after LOAD SHALL have no effect.
REQ-016 m==1 SHALL yield result 0; a >= m and b >= m SHALL be handled through the reductions in REQ-008 and REQ-009.

Reset
REQ-017 A synchronous reset SHALL force state=IDLE, result=0, done=0, and clear all internal registers (a_reg, b_reg, m_reg, r, acc, i) to 0.
REQ-018 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL leave no output update.
REQ-019 When start=0, done SHALL be 1 on the first edge after reset deasserts.

Structure
REQ-020 The shared package mod_arith_pkg SHALL hold WIDTH, the state encoding constants (IDLE=0, LOAD=1, REDUCE=2, MUL=3, FIN=4) and the latency constants MMUL_LAT=66 and MMUL_LAT_M0=2.
REQ-021 The combinational sub-module cond_sub SHALL compute (x >= m) ? x-m : x on WIDTH+1 bits; REDUCE and MUL SHALL instantiate it (three instances).
REQ-022 The block SHALL have a single clock domain and no combinational path from any input to any output.

Verification
REQ-023 a=7, b=5, m=11, start pulse SHALL give done=0 at E0+1, then result=2 with done=1 at E0+66.
REQ-024 a=100, b=3, m=7 SHALL give result=6, exercising a>m.
REQ-025 a=b=0xFFFFFFFF with m=0xFFFFFFFE SHALL give result=1; with m=0xFFFFFFFF it SHALL give result=0, exercising full width and the 33-bit carry.
REQ-026 m=0 with any a and b SHALL give result=0 with done=1 at E0+2; m=1 SHALL give result=0 at E0+66.
REQ-027 A second start pulse at E0+10 SHALL be ignored and the first result delivered unchanged at E0+66; reset asserted at E0+30 SHALL give done=0 and result=0, then done=1 one edge after release.
REQ-028 A randomized check of 1000 operand triples SHALL compare results against a reference model, assert fixed latency, and confirm that result holds between operations.
